ssd_view_ctrl: RTL

Selection controller for the seven-segment debug display path. It generates the 4-bit source select for the 12-input, 13-bit debug display multiplexer. Selection changes in two ways: stepping forward or back with two raw push-buttons, or auto-cycling through the sources with a programmable dwell time. It also registers the multiplexer output into a stable display value, which can be frozen for inspection.

---
 rtl/ssd_view_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ssd_view_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ssd_view_ctrl
//
// Selection controller for the seven-segment debug display path. Produces the
// 4-bit source select for the external debug display multiplexer and
// registers the multiplexer output into a stable display value.
//
// The selection moves in two ways:
//    - Two raw push-buttons step it forward or back. Each button is
//      synchronized and debounced, and steps on the press only.
//    - Auto mode cycles through the sources, dwelling DWELL_CYCLES clocks on
//      each one.
// freeze holds the selection, the dwell count and the display value so a
// value can be inspected.
//
// Parameters:
//    NUM_SRC       number of selectable sources (2..16); sel wraps in
//                  0..NUM_SRC-1
//    DWELL_CYCLES  clocks spent on each source in auto mode (>= 2)
//    DEB_CYCLES    consecutive stable cycles needed to accept a button
//                  level change (>= 2)
//
// Ports:
//    clk          system clock, rising edge
//    rst_n        synchronous active-low reset
//    btn_next     raw asynchronous button, steps sel up on press
//    btn_prev     raw asynchronous button, steps sel down on press
//    auto_en      level, enables auto-cycling
//    freeze       level, holds sel, dwell count and ssd_val
//    ssd_in       multiplexer output for the current sel
//    sel          registered source select
//    ssd_val      registered display value
//    sel_changed  one-cycle pulse while sel shows a new value
//    frozen       registered copy of freeze
// ---------------------------------------------------------------------------
module ssd_view_ctrl #(
   parameter int NUM_SRC      = 12,
   parameter int DWELL_CYCLES = 100000000,
   parameter int DEB_CYCLES   = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_next,
   input  logic        btn_prev,
   input  logic        auto_en,
   input  logic        freeze,
   input  logic [12:0] ssd_in,
   output logic [3:0]  sel,
   output logic [12:0] ssd_val,
   output logic        sel_changed,
   output logic        frozen
);

   // Counter widths. The debounce counter only has to hold DEB_CYCLES-1.
   // The dwell counter only has to hold DWELL_CYCLES-1.
   localparam int DEB_W   = $clog2(DEB_CYCLES);
   localparam int DWELL_W = $clog2(DWELL_CYCLES);

   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
   localparam logic [3:0]         SEL_MAX    = 4'(NUM_SRC - 1);

   // Bit 0 of each per-button vector belongs to btn_next.
   // Bit 1 belongs to btn_prev.
   logic [1:0]         sync1_q, sync1_d;
   logic [1:0]         sync2_q, sync2_d;
   logic [1:0]         deb_q, deb_d;
   logic [1:0]         deb_dly_q, deb_dly_d;
   logic [DEB_W-1:0]   deb_cnt_q [2];
   logic [DEB_W-1:0]   deb_cnt_d [2];
   logic [1:0]         step;

   logic [3:0]         sel_q, sel_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [12:0]        ssd_val_q, ssd_val_d;
   logic               sel_changed_q, sel_changed_d;
   logic               frozen_q, frozen_d;

   logic               step_next;
   logic               step_prev;
   logic [3:0]         sel_inc;
   logic [3:0]         sel_dec;

   // Button front end. Each raw button passes through a two-stage
   // synchronizer. The debounced level changes only after the synchronized
   // input has differed from it for DEB_CYCLES consecutive cycles. Any cycle
   // where the input agrees again clears the count, so short glitches are
   // dropped completely.
   always_comb begin
      sync1_d   = {btn_prev, btn_next};
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_dly_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
            end
         end
      end
   end

   // A step is the rising edge of the debounced level, so holding or
   // releasing a button never produces a step.
   assign step      = deb_q & ~deb_dly_q;
   assign step_next = step[0];
   assign step_prev = step[1];

   // Wrapping neighbours of the current selection.
   assign sel_inc = (sel_q == SEL_MAX) ? 4'd0 : sel_q + 4'd1;
   assign sel_dec = (sel_q == 4'd0) ? SEL_MAX : sel_q - 4'd1;

   // Selection, dwell and display update.
   // freeze takes priority and also throws away any step pulse seen in that
   // cycle. A single button step wins over the auto advance and restarts the
   // dwell period. Opposite steps in the same cycle cancel each other.
   // If that happens exactly when the dwell runs out, the advance is
   // suppressed but the dwell still restarts, so the counter never runs past
   // its terminal value.
   // Leaving auto mode clears the dwell, so re-enabling it always starts a
   // full period.
   always_comb begin
      sel_d     = sel_q;
      dwell_d   = dwell_q;
      ssd_val_d = ssd_val_q;
      if (!freeze) begin
         ssd_val_d = ssd_in;
         if (step_next ^ step_prev) begin
            sel_d   = step_next ? sel_inc : sel_dec;
            dwell_d = '0;
         end else if (!auto_en) begin
            dwell_d = '0;
         end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (!(step_next && step_prev)) begin
               sel_d = sel_inc;
            end
         end else begin
            dwell_d = dwell_q + DWELL_ONE;
         end
      end
      sel_changed_d = (sel_d != sel_q);
      frozen_d      = freeze;
   end

   // State registers. Reset is synchronous and overrides everything,
   // including a debounce or dwell that is part way through.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         deb_q         <= '0;
         deb_dly_q     <= '0;
         deb_cnt_q[0]  <= '0;
         deb_cnt_q[1]  <= '0;
         sel_q         <= '0;
         dwell_q       <= '0;
         ssd_val_q     <= '0;
         sel_changed_q <= 1'b0;
         frozen_q      <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         deb_q         <= deb_d;
         deb_dly_q     <= deb_dly_d;
         deb_cnt_q[0]  <= deb_cnt_d[0];
         deb_cnt_q[1]  <= deb_cnt_d[1];
         sel_q         <= sel_d;
         dwell_q       <= dwell_d;
         ssd_val_q     <= ssd_val_d;
         sel_changed_q <= sel_changed_d;
         frozen_q      <= frozen_d;
      end
   end

   assign sel         = sel_q;
   assign ssd_val     = ssd_val_q;
   assign sel_changed = sel_changed_q;
   assign frozen      = frozen_q;

endmodule
